// File: rtl/axi4_mem_guard_if.sv
//------------------------------------------------------------------------------
// axi4_mem_guard_if
// Purpose : AXI4 bundle (AW, W, B, AR, R) carried as one port.
// Ports   : master modport drives AW/W/AR payload and valid plus B/R ready.
//           slave modport drives AW/W/AR ready plus B/R payload and valid.
//------------------------------------------------------------------------------
interface axi4_mem_guard_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              aw_valid;
    logic              aw_ready;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              aw_lock;
    logic [3:0]        aw_cache;
    logic [2:0]        aw_prot;
    logic [3:0]        aw_qos;

    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;

    logic              b_valid;
    logic              b_ready;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;

    logic              ar_valid;
    logic              ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_lock;
    logic [3:0]        ar_cache;
    logic [2:0]        ar_prot;
    logic [3:0]        ar_qos;

    logic              r_valid;
    logic              r_ready;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
               aw_lock, aw_cache, aw_prot, aw_qos,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
               ar_lock, ar_cache, ar_prot, ar_qos,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
               aw_lock, aw_cache, aw_prot, aw_qos,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
               ar_lock, ar_cache, ar_prot, ar_qos,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

// File: rtl/axi4_mem_guard.sv
//------------------------------------------------------------------------------
// axi4_mem_guard
// Purpose : Address-window guard in front of the DDR AXI wrapper. In-window
//           bursts are forwarded with the address rebased to zero; bursts
//           outside the window are answered locally with DECERR once all
//           forwarded traffic in that direction has drained.
// Ports   : clock, reset  - block clock, async active-high reset
//           s_axi         - slave side, faces the Rocket mem master
//           m_axi         - master side, faces the DDR wrapper
//           err_count     - saturating count of completed DECERR bursts
//------------------------------------------------------------------------------
module axi4_mem_guard #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 4,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE  = 32'h0800_0000,
    parameter int unsigned       MAX_OUTST = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    axi4_mem_guard_if.slave         s_axi,
    axi4_mem_guard_if.master        m_axi,
    output logic [15:0]             err_count
);

    localparam int unsigned       CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [1:0]        DECERR  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_ERR}           r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [CNT_W-1:0]  b_outst_q, b_outst_d;
    logic [CNT_W-1:0]  w_credit_q, w_credit_d;
    logic [CNT_W-1:0]  r_outst_q, r_outst_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [7:0]        r_beat_q, r_beat_d;
    logic [15:0]       err_count_q, err_count_d;

    logic [ADDR_W-1:0] aw_off, ar_off;
    logic              aw_in_range, ar_in_range;
    logic              b_room, r_room, w_credit_nz;
    logic              aw_err_ok, ar_err_ok;
    logic              r_err_last;
    logic              wr_err_done, rd_err_done;
    logic              m_aw_hs, m_b_hs, m_w_last_hs, m_ar_hs, m_r_last_hs;
    logic [16:0]       err_sum;

    // Window check on the start address; unsigned wrap makes below-base addresses huge
    assign aw_off      = s_axi.aw_addr - MEM_BASE;
    assign ar_off      = s_axi.ar_addr - MEM_BASE;
    assign aw_in_range = aw_off < MEM_SIZE;
    assign ar_in_range = ar_off < MEM_SIZE;

    assign b_room      = b_outst_q < CNT_MAX;
    assign r_room      = r_outst_q < CNT_MAX;
    assign w_credit_nz = w_credit_q != '0;
    // Local error only once nothing forwarded is still pending in that direction
    assign aw_err_ok   = (b_outst_q == '0) && (w_credit_q == '0);
    assign ar_err_ok   = (r_outst_q == '0);
    assign r_err_last  = r_beat_q == r_len_q;

    // Address-channel payload passthrough
    assign m_axi.aw_id    = s_axi.aw_id;
    assign m_axi.aw_addr  = aw_off;
    assign m_axi.aw_len   = s_axi.aw_len;
    assign m_axi.aw_size  = s_axi.aw_size;
    assign m_axi.aw_burst = s_axi.aw_burst;
    assign m_axi.aw_lock  = s_axi.aw_lock;
    assign m_axi.aw_cache = s_axi.aw_cache;
    assign m_axi.aw_prot  = s_axi.aw_prot;
    assign m_axi.aw_qos   = s_axi.aw_qos;
    assign m_axi.w_data   = s_axi.w_data;
    assign m_axi.w_strb   = s_axi.w_strb;
    assign m_axi.w_last   = s_axi.w_last;
    assign m_axi.ar_id    = s_axi.ar_id;
    assign m_axi.ar_addr  = ar_off;
    assign m_axi.ar_len   = s_axi.ar_len;
    assign m_axi.ar_size  = s_axi.ar_size;
    assign m_axi.ar_burst = s_axi.ar_burst;
    assign m_axi.ar_lock  = s_axi.ar_lock;
    assign m_axi.ar_cache = s_axi.ar_cache;
    assign m_axi.ar_prot  = s_axi.ar_prot;
    assign m_axi.ar_qos   = s_axi.ar_qos;

    assign err_count = err_count_q;

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            b_outst_q   <= '0;
            w_credit_q  <= '0;
            r_outst_q   <= '0;
            w_id_q      <= '0;
            r_id_q      <= '0;
            r_len_q     <= '0;
            r_beat_q    <= '0;
            err_count_q <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            b_outst_q   <= b_outst_d;
            w_credit_q  <= w_credit_d;
            r_outst_q   <= r_outst_d;
            w_id_q      <= w_id_d;
            r_id_q      <= r_id_d;
            r_len_q     <= r_len_d;
            r_beat_q    <= r_beat_d;
            err_count_q <= err_count_d;
        end
    end

    // Write engine: forward, or drain W and answer B with DECERR
    always_comb begin
        w_state_d      = w_state_q;
        w_id_d         = w_id_q;
        wr_err_done    = 1'b0;
        m_axi.aw_valid = 1'b0;
        s_axi.aw_ready = 1'b0;
        m_axi.w_valid  = 1'b0;
        s_axi.w_ready  = 1'b0;
        s_axi.b_valid  = m_axi.b_valid;
        s_axi.b_id     = m_axi.b_id;
        s_axi.b_resp   = m_axi.b_resp;
        m_axi.b_ready  = s_axi.b_ready;
        unique case (w_state_q)
            W_IDLE: begin
                m_axi.w_valid = s_axi.w_valid & w_credit_nz;
                s_axi.w_ready = m_axi.w_ready & w_credit_nz;
                if (aw_in_range) begin
                    m_axi.aw_valid = s_axi.aw_valid & b_room;
                    s_axi.aw_ready = m_axi.aw_ready & b_room;
                end else begin
                    s_axi.aw_ready = aw_err_ok;
                    if (s_axi.aw_valid && aw_err_ok) begin
                        w_id_d    = s_axi.aw_id;
                        w_state_d = W_DRAIN;
                    end
                end
            end
            W_DRAIN: begin
                s_axi.w_ready = 1'b1;
                if (s_axi.w_valid && s_axi.w_last) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axi.b_valid = 1'b1;
                s_axi.b_id    = w_id_q;
                s_axi.b_resp  = DECERR;
                m_axi.b_ready = 1'b0;
                if (s_axi.b_ready) begin
                    wr_err_done = 1'b1;
                    w_state_d   = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read engine: forward, or generate len+1 zero-data DECERR beats
    always_comb begin
        r_state_d      = r_state_q;
        r_id_d         = r_id_q;
        r_len_d        = r_len_q;
        r_beat_d       = r_beat_q;
        rd_err_done    = 1'b0;
        m_axi.ar_valid = 1'b0;
        s_axi.ar_ready = 1'b0;
        s_axi.r_valid  = m_axi.r_valid;
        s_axi.r_id     = m_axi.r_id;
        s_axi.r_data   = m_axi.r_data;
        s_axi.r_resp   = m_axi.r_resp;
        s_axi.r_last   = m_axi.r_last;
        m_axi.r_ready  = s_axi.r_ready;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_in_range) begin
                    m_axi.ar_valid = s_axi.ar_valid & r_room;
                    s_axi.ar_ready = m_axi.ar_ready & r_room;
                end else begin
                    s_axi.ar_ready = ar_err_ok;
                    if (s_axi.ar_valid && ar_err_ok) begin
                        r_id_d    = s_axi.ar_id;
                        r_len_d   = s_axi.ar_len;
                        r_beat_d  = 8'd0;
                        r_state_d = R_ERR;
                    end
                end
            end
            R_ERR: begin
                s_axi.r_valid = 1'b1;
                s_axi.r_id    = r_id_q;
                s_axi.r_data  = '0;
                s_axi.r_resp  = DECERR;
                s_axi.r_last  = r_err_last;
                m_axi.r_ready = 1'b0;
                if (s_axi.r_ready) begin
                    r_beat_d = r_beat_q + 8'd1;
                    if (r_err_last) begin
                        rd_err_done = 1'b1;
                        r_state_d   = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign m_aw_hs     = m_axi.aw_valid & m_axi.aw_ready;
    assign m_b_hs      = m_axi.b_valid & m_axi.b_ready;
    assign m_w_last_hs = m_axi.w_valid & m_axi.w_ready & m_axi.w_last;
    assign m_ar_hs     = m_axi.ar_valid & m_axi.ar_ready;
    assign m_r_last_hs = m_axi.r_valid & m_axi.r_ready & m_axi.r_last;

    // Outstanding counters; simultaneous inc and dec cancel
    always_comb begin
        b_outst_d  = b_outst_q;
        w_credit_d = w_credit_q;
        r_outst_d  = r_outst_q;
        if (m_aw_hs && !m_b_hs) begin
            b_outst_d = b_outst_q + CNT_W'(1);
        end else if (!m_aw_hs && m_b_hs) begin
            b_outst_d = b_outst_q - CNT_W'(1);
        end
        if (m_aw_hs && !m_w_last_hs) begin
            w_credit_d = w_credit_q + CNT_W'(1);
        end else if (!m_aw_hs && m_w_last_hs) begin
            w_credit_d = w_credit_q - CNT_W'(1);
        end
        if (m_ar_hs && !m_r_last_hs) begin
            r_outst_d = r_outst_q + CNT_W'(1);
        end else if (!m_ar_hs && m_r_last_hs) begin
            r_outst_d = r_outst_q - CNT_W'(1);
        end
    end

    // Error counter; both engines may finish in the same cycle
    always_comb begin
        err_sum     = {1'b0, err_count_q} + 17'(wr_err_done) + 17'(rd_err_done);
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

endmodule

// File: doc/axi4_mem_guard.md
Name: axi4_mem_guard

Overview:
- Sits directly upstream of the DDR AXI memory wrapper, between the Rocket mem AXI4 master port and the wrapper's slave port.
- Forwards in-window transactions with the address rebased to zero.
- Terminates out-of-window transactions locally with DECERR instead of letting them alias in DDR.
- Preserves AXI ordering by draining forwarded traffic before it issues any local error response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- ID_W, 4, ID width.
- MEM_BASE, 32'h8000_0000, window base address.
- MEM_SIZE, 32'h0800_0000, window size in bytes (128 MiB).
- MAX_OUTST, 8, maximum forwarded bursts in flight per direction.

Ports:
- clock  in  1  block clock, same domain as the Rocket master.
- reset  in  1  asynchronous active-high reset.
- s_aw_{valid,id,addr,len,size,burst,lock,cache,prot,qos}  in  1/ID_W/ADDR_W/8/3/2/1/4/3/4  slave AW channel; s_aw_ready out 1.
- s_w_{valid,data,strb,last}  in  1/DATA_W/DATA_W/8/1  slave W channel; s_w_ready out 1.
- s_b_{valid,id,resp}  out  1/ID_W/2  slave B channel; s_b_ready in 1.
- s_ar_{valid,id,addr,len,size,burst,lock,cache,prot,qos}  in  as AW  slave AR channel; s_ar_ready out 1.
- s_r_{valid,id,data,resp,last}  out  1/ID_W/DATA_W/2/1  slave R channel; s_r_ready in 1.
- m_*  mirror of all s_* signals with opposite direction  master port to the DDR wrapper.
- err_count  out  16  saturating count of completed DECERR responses.

Behaviour:
- Window check: off = addr - MEM_BASE, computed as an ADDR_W unsigned wrap; in_range = off < MEM_SIZE.
  - The check uses the start address only.
  - m_aw_addr and m_ar_addr carry off. All other AW/AR fields pass through unchanged.
- Counters, all reset to 0:
  - b_outst: +1 on m_aw handshake, -1 on m_b handshake.
  - w_credit: +1 on m_aw handshake, -1 on m_w handshake with wlast.
  - r_outst: +1 on m_ar handshake, -1 on m_r handshake with rlast.
  - A simultaneous inc and dec on the same counter leaves it unchanged.
  - No forward is issued while its counter equals MAX_OUTST.
- Write FSM states: W_IDLE, W_DRAIN, W_RESP. Reset state is W_IDLE.
- W_IDLE:
  - In-range AW: m_aw_valid = s_aw_valid & (b_outst<MAX_OUTST); s_aw_ready = m_aw_ready under the same condition. Combinational, 0-cycle latency.
  - Out-of-range AW: m_aw_valid=0. s_aw_ready=1 only when b_outst==0 and w_credit==0. On that handshake, latch the ID and go to W_DRAIN.
- W forwarding: m_w_valid = s_w_valid & (w_credit>0) & state==W_IDLE; s_w_ready follows the same gating. W beats arriving before their AW stall.
- W_DRAIN: s_w_ready=1, m_w_valid=0, beats are discarded. On the s_w handshake with last, go to W_RESP.
- W_RESP: s_b_valid=1, s_b_id=latched ID, s_b_resp=2'b11, m_b_ready=0. On s_b_ready: err_count+1 (saturating at 16'hFFFF), go to W_IDLE.
- B passthrough: in all states other than W_RESP, s_b_* = m_b_* and m_b_ready = s_b_ready.
- Read FSM states: R_IDLE, R_ERR. Reset state is R_IDLE.
- R_IDLE:
  - In-range AR is forwarded like AW, gated by r_outst<MAX_OUTST.
  - Out-of-range AR is accepted only when r_outst==0. On acceptance, latch ID and len, clear the beat counter, go to R_ERR.
- R_ERR:
  - Outputs: s_r_valid=1, data=0, resp=2'b11, id=latched ID, last=(beat==len).
  - Each s_r handshake increments the beat counter (8-bit).
  - The handshake with last sets err_count+1 and returns to R_IDLE. len=0 gives a single beat.
  - m_r_ready=0 and m_ar_valid=0 while in R_ERR.
- R passthrough: in R_IDLE, s_r_* = m_r_*.
- Outputs must hold stable while valid and not ready.
- The read and write engines are independent and may both be in error states at once. When both complete in the same cycle, err_count increments by 2 (saturating).
- Reset: asynchronous, active-high. Asserting it mid-burst returns both FSMs to IDLE, clears all counters and err_count, and drives every registered-valid output to 0. Combinational passthroughs reflect their inputs gated by the reset-state FSMs.

Test Plan:
- Write, AW addr 0x8000_1000, len 3, then 4 W beats -> m_aw_addr=0x0000_1000, 4 m_w beats, B OKAY with ID passed, err_count=0.
- Read, AR addr 0x9000_0000, id 5, len 7 -> no m_ar_valid; 8 R beats with data 0, resp 2'b11, id 5, last on beat 8 only; err_count=1.
- Forwarded write in flight with its B response delayed 20 cycles, then an out-of-range AW -> s_aw_ready stays 0 until m_b completes. W beats for the error burst are then drained, followed by B DECERR.
- Read back-pressure: s_r_ready toggling 1/0 during an error burst -> s_r data, id and last remain stable while stalled; exactly len+1 beats delivered.
- Push 8 forwarded ARs with m_r withheld -> the 9th AR stalls (s_ar_ready=0) until one rlast completes.
- Assert reset during W_DRAIN after 2 of 4 beats -> s_b_valid=0 and state W_IDLE; the next in-range AW forwards normally.
